sm_accumulator: RTL

SM_ACCUMULATOR -- requirements
Module: sm_accumulator

---
 rtl/sm_accumulator_if.sv | 25 ++
 rtl/sm_accumulator.sv | 124 ++++++++++++
 2 files changed

// File: rtl/sm_accumulator_if.sv
// Term input stream and result output stream of the sign-magnitude accumulator.
interface sm_accumulator_if #(
    parameter int O_VEC = 21,
    parameter int CW    = 8
);
    logic [O_VEC-1:0] in_data;
    logic             in_valid;
    logic             in_last;
    logic             in_ready;
    logic [O_VEC-1:0] out_sum;
    logic             out_sat;
    logic [CW-1:0]    out_count;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output in_data, in_valid, in_last, out_ready,
        input  in_ready, out_sum, out_sat, out_count, out_valid
    );

    modport slave (
        input  in_data, in_valid, in_last, out_ready,
        output in_ready, out_sum, out_sat, out_count, out_valid
    );
endinterface

// File: rtl/sm_accumulator.sv
// Sign-magnitude group accumulator: sums up to MAX_TERMS terms per group with
// magnitude clamping, then presents the result until downstream accepts it.
module sm_accumulator #(
    parameter int O_VEC     = 21,
    parameter int MAX_TERMS = 16,
    parameter int CW        = 8
) (
    input logic            clk,
    input logic            rst_n,
    sm_accumulator_if.slave bus
);
    localparam int MW = O_VEC - 1;
    localparam logic [MW-1:0] MAG_MAX = '1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ACCUM = 2'd1;
    localparam logic [1:0] HOLD  = 2'd2;

    // Returns {sat, sign, magnitude}; -0 operands and zero results are +0.
    function automatic logic [O_VEC:0] sm_add(input logic [O_VEC-1:0] a,
                                              input logic [O_VEC-1:0] b);
        logic          sa, sb, s_r, sat;
        logic [MW-1:0] ma, mb, m_r;
        logic [MW:0]   wide;
        ma   = a[MW-1:0];
        mb   = b[MW-1:0];
        sa   = a[MW] & (ma != '0);
        sb   = b[MW] & (mb != '0);
        sat  = 1'b0;
        wide = '0;
        if (sa == sb) begin
            wide = {1'b0, ma} + {1'b0, mb};
            s_r  = sa;
            if (wide[MW]) begin
                m_r = MAG_MAX;
                sat = 1'b1;
            end else begin
                m_r = wide[MW-1:0];
            end
        end else if (ma >= mb) begin
            m_r = ma - mb;
            s_r = sa;
        end else begin
            m_r = mb - ma;
            s_r = sb;
        end
        if (m_r == '0) s_r = 1'b0;
        return {sat, s_r, m_r};
    endfunction

    logic [1:0]       state_q, state_d;
    logic [O_VEC-1:0] acc_q, acc_d;
    logic [CW-1:0]    count_q, count_d;
    logic             sat_q, sat_d;
    logic [O_VEC-1:0] out_sum_q, out_sum_d;
    logic [CW-1:0]    out_count_q, out_count_d;
    logic             out_sat_q, out_sat_d;

    logic             ready, accept, close;
    logic [O_VEC-1:0] add_a;
    logic [O_VEC:0]   add_res;
    logic [CW-1:0]    cnt_inc;
    logic             sat_new;

    assign ready   = (state_q == IDLE) || (state_q == ACCUM);
    assign accept  = ready && bus.in_valid;
    // A term arriving in IDLE starts from +0 rather than the stale accumulator.
    assign add_a   = (state_q == IDLE) ? '0 : acc_q;
    assign add_res = sm_add(add_a, bus.in_data);
    assign cnt_inc = (state_q == IDLE) ? CW'(1) : count_q + CW'(1);
    assign sat_new = add_res[O_VEC] | ((state_q == ACCUM) & sat_q);
    assign close   = accept && (bus.in_last || (cnt_inc == CW'(MAX_TERMS)));

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        count_d     = count_q;
        sat_d       = sat_q;
        out_sum_d   = out_sum_q;
        out_count_d = out_count_q;
        out_sat_d   = out_sat_q;
        if (accept) begin
            acc_d   = add_res[O_VEC-1:0];
            count_d = cnt_inc;
            sat_d   = sat_new;
            state_d = close ? HOLD : ACCUM;
            if (close) begin
                out_sum_d   = add_res[O_VEC-1:0];
                out_count_d = cnt_inc;
                out_sat_d   = sat_new;
            end
        end else if (state_q == HOLD) begin
            if (bus.out_ready) state_d = IDLE;
        end else if (state_q != ACCUM) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            count_q     <= '0;
            sat_q       <= 1'b0;
            out_sum_q   <= '0;
            out_count_q <= '0;
            out_sat_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            count_q     <= count_d;
            sat_q       <= sat_d;
            out_sum_q   <= out_sum_d;
            out_count_q <= out_count_d;
            out_sat_q   <= out_sat_d;
        end
    end

    assign bus.in_ready  = ready;
    assign bus.out_valid = (state_q == HOLD);
    assign bus.out_sum   = out_sum_q;
    assign bus.out_count = out_count_q;
    assign bus.out_sat   = out_sat_q;
endmodule
